instr_fetch: RTL and testbench

Instruction fetch stage for the RISC-V core. It holds the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake. Each fetched word is presented, with its PC, to the decode stage (the opcode field drives the main controller) over a valid/ready handshake. The next PC is either sequential (+4) or a taken-branch target, which the consumer supplies when it accepts the instruction.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory port
// and hands each word with its PC to decode over a valid/ready handshake.
module instr_fetch #(
   parameter int unsigned     PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [6:0]      Opcode,
   output logic [PC_W-1:0] pc,
   output logic            illegal,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target
);

   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
   localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [PC_W-1:0] r_pc_q;
   logic [PC_W-1:0] w_pc_q_next;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;
   logic [31:0]     r_instr;
   logic [31:0]     w_instr_next;
   logic            r_illegal;
   logic            w_illegal_next;
   logic            w_rdata_illegal;
   logic            w_unused;

   // Target alignment drops the low two bits, so they never reach the PC.
   assign w_unused = &{1'b0, branch_target[1:0]};

   always_comb begin
      w_rdata_illegal = 1'b1;
      case (imem_rdata[6:0])
         7'b0110011,
         7'b0000011,
         7'b0010011,
         7'b0100011,
         7'b1100011: w_rdata_illegal = 1'b0;
         default:    w_rdata_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_pc_q    <= RESET_PC;
         r_pc      <= RESET_PC;
         r_instr   <= NOP_INSTR;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pc_q    <= w_pc_q_next;
         r_pc      <= w_pc_next;
         r_instr   <= w_instr_next;
         r_illegal <= w_illegal_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_pc_q_next    = r_pc_q;
      w_pc_next      = r_pc;
      w_instr_next   = r_instr;
      w_illegal_next = r_illegal;
      case (r_state)
         IDLE: begin
            w_state_next = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               w_instr_next   = imem_rdata;
               w_pc_next      = r_pc_q;
               w_illegal_next = w_rdata_illegal;
               w_state_next   = HOLD;
            end
         end
         HOLD: begin
            if (instr_ready) begin
               // Sequential increment wraps naturally at PC_W bits.
               if (branch_taken) begin
                  w_pc_q_next = {branch_target[PC_W-1:2], 2'b00};
               end else begin
                  w_pc_q_next = r_pc_q + PC_STEP;
               end
               w_state_next = FETCH;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Handshake outputs come straight from registered state; no input reaches them.
   assign imem_req    = (r_state == FETCH);
   assign imem_addr   = r_pc_q;
   assign instr_valid = (r_state == HOLD);
   assign instr       = r_instr;
   assign Opcode      = r_instr[6:0];
   assign pc          = r_pc;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch;

   localparam int unsigned PC_W = 9;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack = 1'b0;
   logic [31:0]     imem_rdata = 32'h0;
   logic            instr_valid;
   logic            instr_ready = 1'b0;
   logic [31:0]     instr;
   logic [6:0]      Opcode;
   logic [PC_W-1:0] pc;
   logic            illegal;
   logic            branch_taken = 1'b0;
   logic [PC_W-1:0] branch_target = '0;

   instr_fetch #(.PC_W(PC_W), .RESET_PC(9'h000)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .Opcode        (Opcode),
      .pc            (pc),
      .illegal       (illegal),
      .branch_taken  (branch_taken),
      .branch_target (branch_target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [31:0] mem [0:127];
   int          ack_delay = 0;
   logic        inject_ack = 1'b0;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
      mem[0]   = 32'h0000_0033;
      mem[1]   = 32'h0050_0093;
      mem[2]   = 32'h0000_2003;
      mem[3]   = 32'h0080_2023;
      mem[16]  = 32'h0000_006F;
      mem[17]  = 32'h0000_0063;
      mem[127] = 32'h0000_006F;
   end

   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (imem_req) begin
            if (wcnt >= ack_delay) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr[8:2]];
               wcnt       = 0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = 32'h0;
               wcnt++;
            end
         end else begin
            imem_ack   = inject_ack;
            imem_rdata = 32'hDEAD_BEEF;
            wcnt       = 0;
         end
      end
   end

   // ---------------- behavioural model ----------------
   logic            m_req;
   logic            m_valid;
   logic [PC_W-1:0] m_addr;
   logic [PC_W-1:0] m_pc;
   logic [31:0]     m_instr;
   logic            m_ill;

   function automatic logic exp_illegal(input logic [6:0] op);
      return !(op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011});
   endfunction

   task automatic model_reset();
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_addr  = 9'h000;
      m_pc    = 9'h000;
      m_instr = 32'h0000_0013;
      m_ill   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_req"},     imem_req,    32'd0);
      chk({pfx, "_addr"},    imem_addr,   32'h000);
      chk({pfx, "_valid"},   instr_valid, 32'd0);
      chk({pfx, "_instr"},   instr,       32'h0000_0013);
      chk({pfx, "_opcode"},  Opcode,      32'h13);
      chk({pfx, "_pc"},      pc,          32'h000);
      chk({pfx, "_illegal"}, illegal,     32'd0);
   endtask

   always @(posedge reset) model_reset();

   initial begin
      logic [PC_W-1:0] tgt;
      model_reset();
      forever begin
         @(negedge clk);
         if (reset) begin
            model_reset();
            check_reset_outputs("m_rst");
         end else begin
            chk("m_req", imem_req, m_req);
            chk("m_valid", instr_valid, m_valid);
            if (m_req) chk("m_addr", imem_addr, m_addr);
            if (m_valid) begin
               chk("m_instr", instr, m_instr);
               chk("m_opcode", Opcode, m_instr[6:0]);
               chk("m_pc", pc, m_pc);
               chk("m_illegal", illegal, m_ill);
            end
            // Advance to what must be visible after the coming rising edge.
            if (!m_req && !m_valid) begin
               m_req = 1'b1;
            end else if (m_req && imem_ack) begin
               m_req   = 1'b0;
               m_valid = 1'b1;
               m_instr = imem_rdata;
               m_pc    = m_addr;
               m_ill   = exp_illegal(imem_rdata[6:0]);
            end else if (m_valid && instr_ready) begin
               m_valid = 1'b0;
               m_req   = 1'b1;
               tgt     = branch_target & 9'h1FC;
               m_addr  = branch_taken ? tgt : m_pc + 9'd4;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic accept(input logic br, input logic [PC_W-1:0] tgt);
      @(posedge clk);
      #1;
      instr_ready   = 1'b1;
      branch_taken  = br;
      branch_target = tgt;
      @(posedge clk);
      #1;
      instr_ready   = 1'b0;
      branch_taken  = 1'b0;
      $display("accept: branch=%0d target=%h", br, tgt);
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (instr_valid) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL %s: instr_valid got 0 expected 1 within 20 cycles", name);
      end else begin
         $display("deliver: pc=%h instr=%h illegal=%0d", pc, instr, illegal);
      end
   endtask

   initial begin
      instr_ready = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Sequential fetch, zero-wait memory, consumer always ready
      @(negedge clk); chk("a_idle_req", imem_req, 0); chk("a_idle_valid", instr_valid, 0);
      @(negedge clk); chk("a_req0", imem_req, 1); chk("a_addr0", imem_addr, 9'h000);
      @(negedge clk); chk("a_valid0", instr_valid, 1); chk("a_instr0", instr, 32'h0000_0033);
      chk("a_pc0", pc, 9'h000);
      @(negedge clk); chk("a_req1", imem_req, 1); chk("a_addr1", imem_addr, 9'h004);
      @(negedge clk); chk("a_valid1", instr_valid, 1); chk("a_pc1", pc, 9'h004);
      @(negedge clk); chk("a_req2", imem_req, 1); chk("a_addr2", imem_addr, 9'h008);
      $display("seq: three fetches issued");

      // Asynchronous reset while holding an instruction
      @(posedge clk);
      #1 instr_ready = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_outputs("b_rst_hold");
      inject_ack = 1'b1;
      ack_delay  = 3;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      inject_ack = 1'b0;
      $display("reset: released after HOLD-phase reset");

      @(negedge clk); chk("b_idle_req", imem_req, 0); chk("b_idle_valid", instr_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("b_w0_req", imem_req, 1); chk("b_w0_addr", imem_addr, 9'h000);
      end
      @(negedge clk); chk("b_w0_valid", instr_valid, 1); chk("b_w0_instr", instr, 32'h0000_0033);
      accept(1'b0, 9'h000);

      // Wait states at 0x004, with a branch request that must be ignored in FETCH
      branch_taken  = 1'b1;
      branch_target = 9'h100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("b_w1_req", imem_req, 1); chk("b_w1_addr", imem_addr, 9'h004);
      end
      @(negedge clk); chk("b_w1_valid", instr_valid, 1);

      // Backpressure with an ack injected during HOLD
      @(posedge clk);
      #1 inject_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("c_hold_valid", instr_valid, 1);
         chk("c_hold_req", imem_req, 0);
         chk("c_hold_instr", instr, 32'h0050_0093);
         chk("c_hold_pc", pc, 9'h004);
         chk("c_hold_opcode", Opcode, 7'b0010011);
         @(posedge clk);
         #1 inject_ack = 1'b0;
      end
      branch_taken = 1'b0;
      ack_delay    = 0;
      accept(1'b0, 9'h000);
      @(negedge clk); chk("c_seq_req", imem_req, 1); chk("c_seq_addr", imem_addr, 9'h008);

      // Branch redirect with misaligned target
      wait_valid("d_wait8");
      chk("d_instr8", instr, 32'h0000_2003); chk("d_pc8", pc, 9'h008);
      accept(1'b1, 9'h043);
      @(negedge clk); chk("d_br_req", imem_req, 1); chk("d_br_addr", imem_addr, 9'h040);
      wait_valid("d_wait40");
      chk("d_pc40", pc, 9'h040); chk("d_ill40", illegal, 1);

      // Wrap at the top of the address space, illegal then legal opcode
      accept(1'b1, 9'h1FE);
      @(negedge clk); chk("e_top_addr", imem_addr, 9'h1FC);
      wait_valid("e_wait1fc");
      chk("e_pc1fc", pc, 9'h1FC); chk("e_ill1fc", illegal, 1);
      chk("e_op1fc", Opcode, 7'b1101111);
      accept(1'b0, 9'h000);
      @(negedge clk); chk("e_wrap_req", imem_req, 1); chk("e_wrap_addr", imem_addr, 9'h000);
      wait_valid("e_wait0");
      chk("e_ill0", illegal, 0); chk("e_instr0", instr, 32'h0000_0033);

      // Asynchronous reset in the middle of a waited fetch
      ack_delay = 2;
      accept(1'b0, 9'h000);
      @(negedge clk); chk("f_req", imem_req, 1); chk("f_addr", imem_addr, 9'h004);
      #1 reset = 1'b1;
      #1 check_reset_outputs("f_rst_fetch");
      @(posedge clk);
      #1 reset = 1'b0;
      $display("reset: released after FETCH-phase reset");
      @(negedge clk); chk("f_idle_req", imem_req, 0); chk("f_idle_valid", instr_valid, 0);
      @(negedge clk); chk("f_restart_req", imem_req, 1); chk("f_restart_addr", imem_addr, 9'h000);

      @(posedge clk);
      #1 instr_ready = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time got 100000 expected completion earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
